// File: rtl/polinomio_horner.sv
// Polynomial evaluator using Horner's method, one multiply-add per cycle, with a coefficient
// register file. Define SATURATE_EN to clamp overflowing steps to all-ones instead of wrapping.
module polinomio_horner #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DEGREE = 2,
  parameter int unsigned AW     = $clog2(DEGREE + 1)
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             inicio,
  input  logic [WIDTH-1:0] X,
  input  logic             coef_we,
  input  logic [AW-1:0]    coef_addr,
  input  logic [WIDTH-1:0] coef_data,
  output logic [WIDTH-1:0] Resultado,
  output logic             pronto,
  output logic             ocupado,
  output logic             ovf,
  output logic             LED
);

  typedef enum logic [1:0] {StIdle, StLoad, StStep, StDone} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   coef_q [DEGREE+1];
  logic [WIDTH-1:0]   x_q, acc_q, res_q;
  logic [AW-1:0]      idx_q;
  logic               ovf_q, led_q, pronto_q, ocupado_q;

  logic [WIDTH-1:0]   acc_d;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH:0]   sum;
  logic               step_ovf;

  // Full-precision multiply-add; any bit at or above WIDTH means the step overflowed.
  always_comb begin
    prod     = {{WIDTH{1'b0}}, acc_q} * {{WIDTH{1'b0}}, x_q};
    sum      = {1'b0, prod} + {{(WIDTH + 1){1'b0}}, coef_q[idx_q]};
    step_ovf = |sum[2*WIDTH:WIDTH];
`ifdef SATURATE_EN
    acc_d    = step_ovf ? '1 : sum[WIDTH-1:0];
`else
    acc_d    = sum[WIDTH-1:0];
`endif
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      x_q       <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      res_q     <= '0;
      ovf_q     <= 1'b0;
      led_q     <= 1'b0;
      pronto_q  <= 1'b0;
      ocupado_q <= 1'b0;
      for (int i = 0; i <= int'(DEGREE); i++) begin
        coef_q[i] <= '0;
      end
    end else begin
      pronto_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Coefficients only change in IDLE so an evaluation always sees a stable set.
          if (coef_we && (int'(coef_addr) <= int'(DEGREE))) begin
            coef_q[coef_addr] <= coef_data;
          end
          if (inicio) begin
            x_q       <= X;
            ovf_q     <= 1'b0;
            led_q     <= 1'b0;
            ocupado_q <= 1'b1;
            state_q   <= StLoad;
          end
        end
        StLoad: begin
          acc_q   <= coef_q[DEGREE];
          idx_q   <= AW'(DEGREE - 1);
          state_q <= StStep;
        end
        StStep: begin
          acc_q <= acc_d;
          idx_q <= idx_q - AW'(1);
          if (step_ovf) begin
            ovf_q <= 1'b1;
          end
          if (idx_q == '0) begin
            res_q    <= acc_d;
            pronto_q <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone: begin
          led_q     <= 1'b1;
          ocupado_q <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign Resultado = res_q;
  assign pronto    = pronto_q;
  assign ocupado   = ocupado_q;
  assign ovf       = ovf_q;
  assign LED       = led_q;

endmodule

// File: tb/tb_polinomio_horner.sv
// Randomised self-checking bench for polinomio_horner: a DEGREE=2/WIDTH=16 instance and a
// DEGREE=4/WIDTH=8 instance, both checked against a power-sum reference model.
module tb_polinomio_horner;

  logic ck = 1'b0;
  logic rst;
  always #5 ck = ~ck;

  // Instance A: defaults (WIDTH=16, DEGREE=2)
  logic        inicio_a, coef_we_a;
  logic [15:0] x_a, cd_a;
  logic [1:0]  ca_a;
  logic [15:0] res_a;
  logic        pronto_a, ocup_a, ovf_a, led_a;

  // Instance B: WIDTH=8, DEGREE=4
  logic        inicio_b, coef_we_b;
  logic [7:0]  x_b, cd_b;
  logic [2:0]  ca_b;
  logic [7:0]  res_b;
  logic        pronto_b, ocup_b, ovf_b, led_b;

  polinomio_horner u_dut_a (
    .ck(ck), .rst(rst), .inicio(inicio_a), .X(x_a), .coef_we(coef_we_a), .coef_addr(ca_a),
    .coef_data(cd_a), .Resultado(res_a), .pronto(pronto_a), .ocupado(ocup_a), .ovf(ovf_a),
    .LED(led_a)
  );

  polinomio_horner #(.WIDTH(8), .DEGREE(4)) u_dut_b (
    .ck(ck), .rst(rst), .inicio(inicio_b), .X(x_b), .coef_we(coef_we_b), .coef_addr(ca_b),
    .coef_data(cd_b), .Resultado(res_b), .pronto(pronto_b), .ocupado(ocup_b), .ovf(ovf_b),
    .LED(led_b)
  );

  int n_checks = 0;
  int n_errors = 0;
  longint unsigned mc_a [5];
  longint unsigned mc_b [5];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Result = sum c[i]*x^i mod 2^w; ovf = some Horner partial sum exceeded 2^w-1.
  function automatic logic [16:0] model(input int unsigned deg, input int unsigned w,
                                        input longint unsigned c [5], input longint unsigned x);
    longint unsigned m, p, xp, s, acc;
    bit o;
    m  = (64'd1 << w) - 1;
    p  = 0;
    xp = 1;
    for (int i = 0; i <= int'(deg); i++) begin
      p  = (p + c[i] * xp) & m;
      xp = (xp * x) & m;
    end
    acc = c[deg];
    o   = 1'b0;
    for (int i = int'(deg) - 1; i >= 0; i--) begin
      s = acc * x + c[i];
      if (s > m) begin
        o = 1'b1;
        s = m;
      end
      acc = s;
    end
`ifdef SATURATE_EN
    p = acc;
`endif
    return {o, p[15:0]};
  endfunction

  task automatic write_a(input int addr, input logic [15:0] data);
    @(negedge ck);
    coef_we_a = 1'b1;
    ca_a      = 2'(addr);
    cd_a      = data;
    if (addr <= 2) mc_a[addr] = data;
    @(negedge ck);
    coef_we_a = 1'b0;
  endtask

  task automatic write_b(input int addr, input logic [7:0] data);
    @(negedge ck);
    coef_we_b = 1'b1;
    ca_b      = 3'(addr);
    cd_b      = data;
    if (addr <= 4) mc_b[addr] = data;
    @(negedge ck);
    coef_we_b = 1'b0;
  endtask

  // disturb: retrigger + c0 write while busy; co_we: c0 write on the accepting edge.
  task automatic eval_a(input logic [15:0] x, input string tag, input bit disturb,
                        input bit co_we, input logic [15:0] co_d);
    logic [16:0] e;
    int lat, pulses;
    @(negedge ck);
    x_a      = x;
    inicio_a = 1'b1;
    if (co_we) begin
      coef_we_a = 1'b1;
      ca_a      = 2'd0;
      cd_a      = co_d;
      mc_a[0]   = co_d;
    end
    e = model(2, 16, mc_a, x);
    @(negedge ck);
    inicio_a  = 1'b0;
    coef_we_a = 1'b0;
    x_a       = 16'($urandom);
    check({tag, "_busy"}, ocup_a, 1);
    lat    = 0;
    pulses = 0;
    for (int n = 1; n <= 7; n++) begin
      @(negedge ck);
      if (disturb && n == 1) begin
        inicio_a  = 1'b1;
        coef_we_a = 1'b1;
        ca_a      = 2'd0;
        cd_a      = 16'h00FF;
      end else if (disturb && n == 2) begin
        inicio_a  = 1'b0;
        coef_we_a = 1'b0;
      end
      if (pronto_a) begin
        pulses++;
        if (lat == 0) lat = n;
      end
    end
    check({tag, "_lat"}, lat, 3);
    check({tag, "_pulses"}, pulses, 1);
    check({tag, "_res"}, res_a, {16'd0, e[15:0]});
    check({tag, "_ovf"}, ovf_a, {31'd0, e[16]});
    check({tag, "_led"}, led_a, 1);
    check({tag, "_idle"}, ocup_a, 0);
  endtask

  task automatic eval_b(input logic [7:0] x, input string tag);
    logic [16:0] e;
    int lat, pulses;
    e = model(4, 8, mc_b, x);
    @(negedge ck);
    x_b      = x;
    inicio_b = 1'b1;
    @(negedge ck);
    inicio_b = 1'b0;
    lat      = 0;
    pulses   = 0;
    for (int n = 1; n <= 9; n++) begin
      @(negedge ck);
      if (pronto_b) begin
        pulses++;
        if (lat == 0) lat = n;
      end
    end
    check({tag, "_lat"}, lat, 5);
    check({tag, "_pulses"}, pulses, 1);
    check({tag, "_res"}, res_b, {24'd0, e[7:0]});
    check({tag, "_ovf"}, ovf_b, {31'd0, e[16]});
    check({tag, "_led"}, led_b, 1);
  endtask

  initial begin
    int pulses;
    logic [15:0] m;
    rst = 1'b1;
    inicio_a = 0; coef_we_a = 0; x_a = 0; cd_a = 0; ca_a = 0;
    inicio_b = 0; coef_we_b = 0; x_b = 0; cd_b = 0; ca_b = 0;
    for (int i = 0; i < 5; i++) begin
      mc_a[i] = 0;
      mc_b[i] = 0;
    end
    repeat (2) @(negedge ck);
    rst = 1'b0;
    @(negedge ck);
    check("rst_res", res_a, 0);
    check("rst_pronto", pronto_a, 0);
    check("rst_ocupado", ocup_a, 0);
    check("rst_ovf", ovf_a, 0);
    check("rst_led", led_a, 0);

    // 3x^2 + 2x + 1 at x=5
    write_a(2, 16'd3); write_a(1, 16'd2); write_a(0, 16'd1);
    eval_a(16'd5, "quad", 0, 0, 0);
    check("quad_const", res_a, 86);

    // Overflow: 0x100 * 0x100
    write_a(2, 16'h0100); write_a(1, 16'h0000); write_a(0, 16'h0000);
    eval_a(16'h0100, "ovf", 0, 0, 0);
`ifdef SATURATE_EN
    check("ovf_const", res_a, 32'hFFFF);
`else
    check("ovf_const", res_a, 32'h0000);
`endif

    // Retrigger and coefficient write while busy are both ignored
    write_a(2, 16'd3); write_a(1, 16'd2); write_a(0, 16'd1);
    eval_a(16'd5, "busy_ign", 1, 0, 0);
    eval_a(16'd0, "c0_kept", 0, 0, 0);

    // X=0 yields c0; out-of-range address has no effect
    write_a(0, 16'h1234);
    write_a(3, 16'hFFFF);
    eval_a(16'd0, "x0", 0, 0, 0);
    check("x0_const", res_a, 32'h1234);

    // Write on the accepting edge is visible to that evaluation
    eval_a(16'd7, "cowrite", 0, 1, 16'h0042);

    for (int t = 0; t < 12; t++) begin
      m = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h000F;
      for (int i = 0; i <= 2; i++) write_a(i, 16'($urandom) & m);
      eval_a(16'($urandom) & m, "rand", 0, 0, 0);
    end

    // Asynchronous reset two edges into an evaluation
    write_a(2, 16'd3); write_a(1, 16'd2); write_a(0, 16'd1);
    eval_a(16'd5, "pre_rst", 0, 0, 0);
    @(negedge ck);
    x_a = 16'd9;
    inicio_a = 1'b1;
    @(negedge ck);
    inicio_a = 1'b0;
    repeat (2) @(negedge ck);
    rst = 1'b1;
    #1;
    check("mid_rst_res", res_a, 0);
    check("mid_rst_pronto", pronto_a, 0);
    check("mid_rst_ocupado", ocup_a, 0);
    check("mid_rst_ovf", ovf_a, 0);
    check("mid_rst_led", led_a, 0);
    @(negedge ck);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mc_a[i] = 0;
      mc_b[i] = 0;
    end
    pulses = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge ck);
      if (pronto_a) pulses++;
    end
    check("mid_rst_nopulse", pulses, 0);
    eval_a(16'($urandom), "post_rst", 0, 0, 0);
    check("post_rst_const", res_a, 0);

    // DEGREE=4, WIDTH=8 instance
    for (int i = 0; i <= 4; i++) write_b(i, 8'd1);
    eval_b(8'd2, "deg4");
    check("deg4_const", res_b, 31);
    eval_b(8'hFF, "deg4_ovf");
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i <= 4; i++) write_b(i, 8'($urandom));
      eval_b(8'($urandom_range(0, 3)), "deg4_rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
